// File: rtl/ptp_fe_uart_pkg.sv
// Shared definitions for the paper-tape-punch front-end UART.
// PTP_FE_PARITY_EN selects 8E1 framing (11 bit times) instead of 8N1 (10 bit times).
package ptp_fe_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef PTP_FE_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } req_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PAR,
    T_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ptp_fe_uart_fifo.sv
// Single-clock frame FIFO with wrap-bit pointers; contents are discarded on reset.
module ptp_fe_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    level   = wr_ptr - rd_ptr;
    full    = (level == {1'b1, {AW{1'b0}}});
    empty   = (level == '0);
    do_pop  = pop && !empty;
    // a simultaneous pop frees the slot, so a push into a full FIFO is legal then
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ptp_fe_uart.sv
// Punch front-end: pulls one frame per fe_data_rq, buffers it and sends it as async serial.
// Define PTP_FE_PARITY_EN for an even-parity bit between data and stop.
module ptp_fe_uart
  import ptp_fe_uart_pkg::*;
#(
  parameter int unsigned CLKDIV  = 434,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fe_data_rq,
  output logic             s_read,
  input  logic [31:0]      s_readdata,
  output logic             tx,
  output logic [FIFO_AW:0] fifo_level,
  output logic             tx_busy
);

  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKDIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  req_state_t rq_state, rq_state_n;
  tx_state_t  tx_state, tx_state_n;

  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] dout;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 tx_n, bit_end;
`ifdef PTP_FE_PARITY_EN
  logic                 par, par_n;
`endif

  logic unused_rd;
  assign unused_rd = ^s_readdata[31:DATA_BITS];

  ptp_fe_fifo #(
    .DW (DATA_BITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (s_readdata[DATA_BITS-1:0]),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rq_state <= IDLE;
    else       rq_state <= rq_state_n;
  end

  always_comb begin
    rq_state_n = rq_state;
    push       = 1'b0;
    case (rq_state)
      IDLE: if (fe_data_rq && !full) rq_state_n = READ;
      READ: begin
        push       = 1'b1;
        rq_state_n = HOLD;
      end
      HOLD: if (!fe_data_rq) rq_state_n = IDLE;
      default: rq_state_n = IDLE;
    endcase
    s_read = push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= T_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
`ifdef PTP_FE_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shreg    <= sh_n;
      tx       <= tx_n;
`ifdef PTP_FE_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    sh_n       = shreg;
    pop        = 1'b0;
    tx_n       = 1'b1;
`ifdef PTP_FE_PARITY_EN
    par_n      = par;
`endif
    bit_end = (cnt == CNT_MAX);
    if (tx_state != T_IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);

    case (tx_state)
      T_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cnt_n      = '0;
          tx_state_n = T_START;
        end
      end
      T_START: begin
        if (bit_end) begin
          bit_n      = '0;
          tx_state_n = T_DATA;
        end
      end
      T_DATA: begin
        if (bit_end) begin
          sh_n = shreg >> 1;
          if (bit_idx == LAST_BIT) begin
`ifdef PTP_FE_PARITY_EN
            tx_state_n = T_PAR;
`else
            tx_state_n = T_STOP;
`endif
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
`ifdef PTP_FE_PARITY_EN
      T_PAR: if (bit_end) tx_state_n = T_STOP;
`endif
      T_STOP: begin
        // chain straight into the next start bit so queued frames leave with no idle gap
        if (bit_end) begin
          if (!empty) begin
            pop        = 1'b1;
            tx_state_n = T_START;
          end else begin
            tx_state_n = T_IDLE;
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase

    if (pop) begin
      sh_n = dout;
`ifdef PTP_FE_PARITY_EN
      par_n = even_parity(dout);
`endif
    end

    case (tx_state_n)
      T_START: tx_n = 1'b0;
      T_DATA:  tx_n = sh_n[0];
`ifdef PTP_FE_PARITY_EN
      T_PAR:   tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != T_IDLE);

endmodule

// File: tb/tb_ptp_fe_uart.sv
// Self-checking bench for ptp_fe_uart: serial receiver + scoreboard, table-driven requests, corner sequences.
module tb_ptp_fe_uart;
  import ptp_fe_uart_pkg::*;

  localparam int unsigned CLKDIV    = 16;
  localparam int unsigned FIFO_AW   = 4;
  localparam int unsigned DEPTH     = 2**FIFO_AW;
  localparam int unsigned FRAME_CYC = CLKDIV * FRAME_BITS;
  localparam int unsigned LIMIT     = 24 * FRAME_CYC + 200;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fe_data_rq = 1'b0;
  logic [31:0]      s_readdata = '0;
  logic             s_read;
  logic             tx;
  logic [FIFO_AW:0] fifo_level;
  logic             tx_busy;

  always #5 clk = ~clk;

  ptp_fe_uart #(
    .CLKDIV  (CLKDIV),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fe_data_rq (fe_data_rq),
    .s_read     (s_read),
    .s_readdata (s_readdata),
    .tx         (tx),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int unsigned rd_cnt = 0, rd_long = 0, full_read = 0, max_level = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // bus monitor
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (s_read === 1'b1) begin
        rd_cnt++;
        if (fifo_level == DEPTH) full_read++;
        if (prev) rd_long++;
      end
      prev = (s_read === 1'b1);
      if (fifo_level > max_level) max_level = fifo_level;
    end
  end

  task automatic rx_wait(input int unsigned n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // serial receiver, mid-bit sampling, compares against the scoreboard
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    bit ab;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        ab = 1'b0;
        rx_wait(CLKDIV/2, ab);
        if (!ab) chk("rx_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          rx_wait(CLKDIV, ab);
          b[i] = tx;
        end
`ifdef PTP_FE_PARITY_EN
        rx_wait(CLKDIV, ab);
        if (!ab) chk("rx_parity", tx, ^b);
`endif
        rx_wait(CLKDIV, ab);
        if (!ab) begin
          chk("rx_stop", tx, 1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected actual=%0h required=no_frame", b);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", b, e);
          end
        end
      end
    end
  end

  task automatic do_req(input logic [7:0] d, input int unsigned hold,
                        output int unsigned lat, output logic [FIFO_AW:0] lvl);
    int unsigned c;
    logic [31:0] r;
    @(negedge clk);
    r = $urandom;
    s_readdata = {r[31:8], d};
    fe_data_rq = 1'b1;
    exp_q.push_back(d);
    lat = 0;
    lvl = '0;
    while (s_read !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (s_read !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=no_s_read required=s_read");
      void'(exp_q.pop_back());
      fe_data_rq = 1'b0;
      return;
    end
    @(negedge clk);
    lvl = fifo_level;
    s_readdata = $urandom;
    c = lat + 1;
    while (c < hold) begin
      @(negedge clk);
      c++;
    end
    fe_data_rq = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0 || fifo_level != 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < LIMIT), 1);
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned hold;
    int unsigned reads;
    int unsigned lat;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    int unsigned lat, bad, r0, w;
    logic [FIFO_AW:0] lvl;
    logic [7:0]  v;
    logic        eb;

    vecs[0] = '{8'o123, 1,  1, 1};
    vecs[1] = '{8'hA5,  3,  1, 1};
    vecs[2] = '{8'h00,  50, 1, 1};
    vecs[3] = '{8'hFF,  2,  1, 1};
    vecs[4] = '{8'h80,  7,  1, 1};
    vecs[5] = '{8'h01,  20, 1, 1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_s_read", s_read, 0);
    chk("rst_tx", tx, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", tx_busy, 0);
    reset = 1'b0;

    // quiet line with no requests
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || s_read !== 1'b0 || fifo_level != 0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_reads", rd_cnt, 0);

    // single 0o123 frame: latency and waveform
    v = 8'o123;
    @(negedge clk);
    s_readdata = {24'h5A5A5A, v};
    fe_data_rq = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    chk("rd_latency", s_read, 1);
    chk("pre_push_level", fifo_level, 0);
    @(negedge clk);
    s_readdata = $urandom;
    fe_data_rq = 1'b0;
    chk("read_once", s_read, 0);
    chk("push_level", fifo_level, 1);
    @(negedge clk);
    chk("pop_level", fifo_level, 0);
    chk("pop_busy", tx_busy, 1);
    w = 0;
    while (tx === 1'b0 && w < 2*CLKDIV) begin
      w++;
      @(negedge clk);
    end
    chk("start_width", w, CLKDIV);
    repeat (CLKDIV/2) @(negedge clk);
    for (int i = 0; i < FRAME_BITS - 1; i++) begin
      if (i > 0) repeat (CLKDIV) @(negedge clk);
      if (i < 8)                    eb = v[i];
      else if (i == FRAME_BITS - 2) eb = 1'b1;
      else                          eb = ^v;
      chk($sformatf("bit%0d", i), tx, eb);
    end
    wait_drain("drain_single");

    // table-driven requests with varying rq hold times
    for (int k = 0; k < 6; k++) begin
      r0 = rd_cnt;
      do_req(vecs[k].data, vecs[k].hold, lat, lvl);
      chk($sformatf("vec%0d_lat", k), lat, vecs[k].lat);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_reads", k), rd_cnt - r0, vecs[k].reads);
      wait_drain($sformatf("vec%0d_drain", k));
    end

    // back-pressure: 20 requests against a 16-deep FIFO
    r0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      do_req(8'(i), 1, lat, lvl);
      if (i >= DEPTH) chk($sformatf("bp_level%0d", i), lvl, DEPTH);
      if (i == DEPTH + 1) chk("bp_stalled", (lat > CLKDIV), 1);
    end
    chk("bp_max_level", max_level, DEPTH);
    wait_drain("bp_drain");
    chk("bp_reads", rd_cnt - r0, 20);

    // reset in the middle of a data bit with three frames queued
    for (int i = 0; i < 4; i++) do_req(8'hC0 + 8'(i), 1, lat, lvl);
    chk("mid_queued", lvl, 3);
    repeat (2*CLKDIV + CLKDIV/2) @(negedge clk);
    chk("mid_busy", tx_busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", tx_busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    r0 = rd_cnt;
    bad = 0;
    repeat (3*FRAME_CYC) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level != 0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_reads", rd_cnt - r0, 0);

    chk("s_read_width", rd_long, 0);
    chk("read_when_full", full_read, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
